// File: rtl/main_mem_pkg.sv
// Shared types and geometry for the main-memory controller and its word array.
package main_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_BURST = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int WORD_BITS        = 32;
    localparam int LINE_WORDS       = 16;
    localparam int LINE_BITS        = 512;
    localparam int LINE_OFFSET_BITS = 6;
    localparam int BEAT_BITS        = 4;

    // Zero-extends a word index so it can be mixed into a data word.
    function automatic logic [WORD_BITS-1:0] index_key(input logic [WORD_BITS-1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/main_mem_ctrl_word_array.sv
// Single-port synchronous word RAM, one read or write per cycle, 1-cycle read latency.
// Words are stored XOR'ed with their own index so a zero-initialised array reads back word i = i.
module mem_word_array
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem_r [DEPTH_WORDS];
    logic [WORD_BITS-1:0] rdata_r;
    logic [WORD_BITS-1:0] key_s;

    assign key_s = index_key({{(WORD_BITS-AW){1'b0}}, addr});

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata ^ key_s;
        end
    end

    // Registered read port (read-first on a simultaneous write).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {WORD_BITS{1'b0}};
        end else begin
            rdata_r <= mem_r[addr] ^ key_s;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller: 64-byte line refills and 32-bit word write-throughs
// over a req/ready handshake, backed by a single-port word array.
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 4,
    parameter int LINE_WORDS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic                 mem_read_req,
    input  logic                 mem_write_req,
    output logic [LINE_BITS-1:0] mem_rdata,
    output logic                 mem_ready,
    output logic                 mem_busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e                 state_r;
    op_e                    op_r;
    logic [AW-1:0]          word_idx_r;
    logic [WORD_BITS-1:0]   wdata_r;
    logic [CW-1:0]          cnt_r;
    logic [BEAT_BITS-1:0]   beat_r;
    logic [LINE_BITS-1:0]   line_buf_r;
    logic [LINE_BITS-1:0]   rdata_r;
    logic                   ready_r;
    logic                   busy_r;

    logic                   ram_we_s;
    logic [AW-1:0]          ram_addr_s;
    logic [WORD_BITS-1:0]   ram_rdata_s;
    logic [AW-1:0]          line_base_s;
    logic [BEAT_BITS-1:0]   beat_next_s;
    logic                   unused_s;

    assign line_base_s = word_idx_r & ~AW'(LINE_WORDS - 1);
    assign beat_next_s = beat_r + 4'd1;
    assign unused_s    = ^{mem_addr[31:AW+2], mem_addr[1:0],
                           line_buf_r[LINE_BITS-1 -: WORD_BITS]};

    // RAM port steering: the line base is addressed during WAIT so beat 0's
    // data is already registered when BURST begins; BURST then runs one word ahead.
    always_comb begin
        ram_we_s   = 1'b0;
        ram_addr_s = word_idx_r;
        case (state_r)
            ST_WAIT: begin
                ram_we_s   = 1'b0;
                ram_addr_s = line_base_s;
            end
            ST_BURST: begin
                ram_we_s   = 1'b0;
                ram_addr_s = line_base_s | AW'(beat_next_s);
            end
            ST_WRITE: begin
                ram_we_s   = ~rst;
                ram_addr_s = word_idx_r;
            end
            default: begin
                ram_we_s   = 1'b0;
                ram_addr_s = word_idx_r;
            end
        endcase
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Transaction FSM with registered handshake outputs and line assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_READ;
            word_idx_r <= {AW{1'b0}};
            wdata_r    <= {WORD_BITS{1'b0}};
            cnt_r      <= {CW{1'b0}};
            beat_r     <= {BEAT_BITS{1'b0}};
            line_buf_r <= {LINE_BITS{1'b0}};
            rdata_r    <= {LINE_BITS{1'b0}};
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    if (mem_read_req || mem_write_req) begin
                        op_r       <= mem_read_req ? OP_READ : OP_WRITE;
                        word_idx_r <= mem_addr[AW+1:2];
                        wdata_r    <= mem_wdata;
                        cnt_r      <= {CW{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= ST_WAIT;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == CW'(LATENCY - 1)) begin
                        cnt_r   <= {CW{1'b0}};
                        beat_r  <= {BEAT_BITS{1'b0}};
                        state_r <= (op_r == OP_READ) ? ST_BURST : ST_WRITE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_BURST: begin
                    line_buf_r[{beat_r, 5'd0} +: WORD_BITS] <= ram_rdata_s;
                    if (beat_r == BEAT_BITS'(LINE_WORDS - 1)) begin
                        rdata_r <= {ram_rdata_s, line_buf_r[LINE_BITS-WORD_BITS-1:0]};
                        ready_r <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        beat_r <= beat_next_s;
                    end
                end
                ST_WRITE: begin
                    ready_r <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rdata = rdata_r;
    assign mem_ready = ready_r;
    assign mem_busy  = busy_r;

endmodule
